i4003_loader: RTL

Parallel-to-serial driver for a chain of i4003 shift registers. It accepts a WIDTH-bit word over a valid/ready handshake and generates the `cp` clock pulses and `serial_in` data stream that shift the word into the chain. It also controls the chain's `enable` output gate. It sits between a CPU-side output port (e.g. a 4004 ROM/RAM I/O line) and one or more cascaded i4003 devices.

---
 rtl/mcs4_pkg.sv | 22 ++
 rtl/i4003_phase_timer.sv | 24 ++
 rtl/i4003_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 constants: i4003 shift-clock timing defaults and loader state encoding.
package mcs4_pkg;

  localparam int I4003_CP_HIGH  = 120;
  localparam int I4003_CP_LOW   = 120;
  localparam int I4003_DATA_DLY = 5;
  localparam int I4003_DATA_LEN = 55;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CP_HI = 2'd1;
  localparam logic [1:0] ST_CP_LO = 2'd2;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that still leaves one bit when n collapses to 1.
  function automatic int cw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i4003_phase_timer.sv
// Loadable down-counter that parks at zero; o_tc marks the last cycle of a phase.
module i4003_phase_timer #(
  parameter int CW = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)            r_cnt <= '0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/i4003_loader.sv
// Serializes a WIDTH-bit word MSB-first into a chain of i4003 shift registers,
// generating cp, serial data and the shared enable gate.
module i4003_loader
  import mcs4_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int CP_HIGH  = I4003_CP_HIGH,
  parameter int CP_LOW   = I4003_CP_LOW,
  parameter int DATA_DLY = I4003_DATA_DLY,
  parameter int DATA_LEN = I4003_DATA_LEN,
  parameter int BLANK    = 1
) (
  input  logic             sysclk,
  input  logic             poc_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             cp,
  output logic             serial_out,
  output logic             enable,
  output logic             busy
);

  if (WIDTH < 1 || CP_HIGH < 1 || CP_LOW < 1 || DATA_DLY < 1 || DATA_LEN < 1 ||
      DATA_DLY + DATA_LEN > CP_HIGH) begin : g_param_chk
    $error("i4003_loader: illegal timing parameters");
  end

  localparam int CW = cw_of(imax(CP_HIGH, CP_LOW));
  localparam int BW = cw_of(WIDTH);

  localparam logic [CW-1:0] HI_LD  = CW'(CP_HIGH - 1);
  localparam logic [CW-1:0] LO_LD  = CW'(CP_LOW - 1);
  // Timer counts down, so phase p corresponds to count CP_HIGH-1-p. These bounds
  // test the count one cycle early so serial_out can be registered.
  localparam logic [CW-1:0] WIN_LO = CW'(CP_HIGH - DATA_DLY - DATA_LEN + 1);
  localparam logic [CW-1:0] WIN_HI = CW'(CP_HIGH - DATA_DLY);
  localparam logic [BW-1:0] LAST   = BW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_cp, r_sout, r_en, r_ready, r_busy;

  logic [1:0]       w_nxt;
  logic             w_accept, w_last, w_win, w_tc, w_tload;
  logic [CW-1:0]    w_cnt, w_tval;

  i4003_phase_timer #(.CW(CW)) u_timer (
    .i_clk   (sysclk),
    .i_rst_n (poc_n),
    .i_load  (w_tload),
    .i_val   (w_tval),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  assign w_accept = load_valid & r_ready;
  assign w_last   = (r_bitcnt == LAST);
  assign w_win    = (r_state == ST_CP_HI) && (w_cnt >= WIN_LO) && (w_cnt <= WIN_HI);

  always_comb begin
    w_nxt   = r_state;
    w_tload = 1'b0;
    w_tval  = HI_LD;
    case (r_state)
      ST_IDLE:  if (w_accept) begin
                  w_nxt   = ST_CP_HI;
                  w_tload = 1'b1;
                end
      ST_CP_HI: if (w_tc) begin
                  w_nxt   = ST_CP_LO;
                  w_tload = 1'b1;
                  w_tval  = LO_LD;
                end
      ST_CP_LO: if (w_tc) begin
                  w_nxt   = w_last ? ST_IDLE : ST_CP_HI;
                  w_tload = !w_last;
                end
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_sreg   <= '0;
      r_cp     <= 1'b0;
      r_sout   <= 1'b0;
      r_en     <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cp    <= (w_nxt == ST_CP_HI);
      r_sout  <= w_win & r_sreg[WIDTH-1];
      r_ready <= (w_nxt == ST_IDLE);
      r_busy  <= (w_nxt != ST_IDLE);
      if (w_accept) begin
        r_sreg   <= load_data;
        r_bitcnt <= '0;
        if (BLANK != 0) r_en <= 1'b0;
      end else if (r_state == ST_CP_LO && w_tc) begin
        if (w_last) begin
          r_en <= 1'b1;
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
          r_sreg   <= r_sreg << 1;
        end
      end
    end
  end

  assign cp         = r_cp;
  assign serial_out = r_sout;
  assign enable     = r_en;
  assign load_ready = r_ready;
  assign busy       = r_busy;

endmodule
